// File: rtl/instr_assembly_queue_pkg.sv
// Dyna-85 instruction-length rules and assembler state type shared by the
// instruction assembly queue.
package dyna85_pkg;

    localparam logic [1:0] ILEN_3_PREFIX = 2'b11;
    localparam logic [1:0] ILEN_2_PREFIX = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OPND = 1'b1
    } asm_state_t;

    // Instruction length from the two opcode MSBs, clamped to what the queue can hold.
    function automatic logic [1:0] ilen(input logic [1:0] prefix, input int max_bytes);
        logic [1:0] raw;
        case (prefix)
            ILEN_3_PREFIX: raw = 2'd3;
            ILEN_2_PREFIX: raw = 2'd2;
            default:       raw = 2'd1;
        endcase
        if (int'(raw) > max_bytes) begin
            raw = 2'(max_bytes);
        end else begin
            raw = raw;
        end
        return raw;
    endfunction

endpackage

// File: rtl/instr_assembly_queue_if.sv
// Fetch-side byte handshake and control-unit-side instruction handshake
// of the instruction assembly queue.
interface instr_assembly_queue_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 3,
    parameter int DEPTH     = 2
);
    localparam int OPND_W = ((MAX_BYTES > 1) ? (MAX_BYTES - 1) : 1) * DATA_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_opcode;
    logic [OPND_W-1:0] out_operand;
    logic [1:0]        out_len;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              asm_busy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand, out_len, count, asm_busy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_opcode, out_operand, out_len, count, asm_busy
    );

endinterface

// File: rtl/instr_assembly_queue_fifo.sv
// Small synchronous FIFO of assembled instructions; flush empties it and
// the head reads as zero whenever the queue is empty.
module instr_queue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             not_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             not_empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [CNT_W-1:0] count_nxt_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualified push/pop and next occupancy.
    always_comb begin
        push_ok_s = push & (count_r < CNT_W'(DEPTH));
        pop_ok_s  = pop & not_empty_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers and occupancy; flush outranks push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            not_empty_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            not_empty_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            not_empty_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign head_data = not_empty_r ? mem_r[rd_ptr_r] : {W{1'b0}};
    assign count     = count_r;
    assign not_empty = not_empty_r;

endmodule

// File: rtl/instr_assembly_queue.sv
// Assembles Dyna-85 instructions (opcode + little-endian operands) from the
// fetched byte stream and queues complete instructions for the control unit.
module instr_assembly_queue
    import dyna85_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 3,
    parameter int DEPTH     = 2
) (
    input logic clk,
    input logic reset,
    instr_assembly_queue_if.slave bus
);
    localparam int OPND_BYTES = (MAX_BYTES > 1) ? (MAX_BYTES - 1) : 1;
    localparam int OPND_W     = OPND_BYTES * DATA_W;
    localparam int IDX_W      = (OPND_BYTES > 1) ? $clog2(OPND_BYTES) : 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int ENTRY_W    = DATA_W + OPND_W + 2;

    typedef struct packed {
        logic [DATA_W-1:0] opcode;
        logic [OPND_W-1:0] operand;
        logic [1:0]        len;
    } entry_t;

    asm_state_t        state_r;
    logic [1:0]        need_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] opcode_r;
    logic [OPND_W-1:0] operand_r;
    logic [1:0]        len_r;
    logic              asm_busy_r;

    logic [1:0]        ilen_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [OPND_W-1:0] operand_s;
    entry_t            entry_s;
    entry_t            head_s;
    logic [CNT_W-1:0]  count_s;
    logic              not_empty_s;

    // Space is judged on the registered count only, so a same-cycle pop never reaches in_ready.
    always_comb begin
        ilen_s     = ilen(bus.in_data[DATA_W-1 -: 2], MAX_BYTES);
        in_ready_s = !bus.flush & (count_s < CNT_W'(DEPTH));
        accept_s   = bus.in_valid & in_ready_s;
        pop_s      = not_empty_s & bus.out_ready;
    end

    // Partial operand with the incoming byte merged at the current index.
    always_comb begin
        operand_s = operand_r;
        for (int b = 0; b < OPND_BYTES; b++) begin
            if (idx_r == IDX_W'(b)) begin
                operand_s[b*DATA_W +: DATA_W] = bus.in_data;
            end else begin
                operand_s[b*DATA_W +: DATA_W] = operand_r[b*DATA_W +: DATA_W];
            end
        end
    end

    // Push the entry on the byte that completes an instruction.
    always_comb begin
        push_s  = 1'b0;
        entry_s = '{opcode: {DATA_W{1'b0}}, operand: {OPND_W{1'b0}}, len: 2'd0};
        case (state_r)
            IDLE: begin
                push_s  = accept_s & (ilen_s == 2'd1);
                entry_s = '{opcode: bus.in_data, operand: {OPND_W{1'b0}}, len: ilen_s};
            end
            OPND: begin
                push_s  = accept_s & (need_r == 2'd1);
                entry_s = '{opcode: opcode_r, operand: operand_s, len: len_r};
            end
            default: begin
                push_s  = 1'b0;
                entry_s = '{opcode: {DATA_W{1'b0}}, operand: {OPND_W{1'b0}}, len: 2'd0};
            end
        endcase
    end

    // Assembler FSM; operand bytes are cleared on each opcode so short instructions carry zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            need_r     <= 2'd0;
            idx_r      <= {IDX_W{1'b0}};
            opcode_r   <= {DATA_W{1'b0}};
            operand_r  <= {OPND_W{1'b0}};
            len_r      <= 2'd0;
            asm_busy_r <= 1'b0;
        end else if (bus.flush) begin
            state_r    <= IDLE;
            need_r     <= 2'd0;
            idx_r      <= {IDX_W{1'b0}};
            operand_r  <= {OPND_W{1'b0}};
            asm_busy_r <= 1'b0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    opcode_r  <= bus.in_data;
                    len_r     <= ilen_s;
                    operand_r <= {OPND_W{1'b0}};
                    idx_r     <= {IDX_W{1'b0}};
                    if (ilen_s == 2'd1) begin
                        need_r     <= 2'd0;
                        asm_busy_r <= 1'b0;
                    end else begin
                        state_r    <= OPND;
                        need_r     <= ilen_s - 2'd1;
                        asm_busy_r <= 1'b1;
                    end
                end
                OPND: begin
                    operand_r <= operand_s;
                    if (need_r == 2'd1) begin
                        state_r    <= IDLE;
                        need_r     <= 2'd0;
                        idx_r      <= {IDX_W{1'b0}};
                        asm_busy_r <= 1'b0;
                    end else begin
                        need_r <= need_r - 2'd1;
                        idx_r  <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    need_r     <= 2'd0;
                    idx_r      <= {IDX_W{1'b0}};
                    asm_busy_r <= 1'b0;
                end
            endcase
        end
    end

    instr_queue_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s),
        .not_empty (not_empty_s)
    );

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = not_empty_s;
    assign bus.out_opcode  = head_s.opcode;
    assign bus.out_operand = head_s.operand;
    assign bus.out_len     = head_s.len;
    assign bus.count       = count_s;
    assign bus.asm_busy    = asm_busy_r;

endmodule

// File: doc/instr_assembly_queue.md
Name: instr_assembly_queue

Overview:
- Successor to the single-byte opcode latch.
- Accepts the fetched byte stream over a valid/ready handshake.
- Assembles 1- to MAX_BYTES-byte Dyna-85 instructions (opcode + little-endian operands) and queues up to DEPTH complete instructions for the control unit.
- Supports pipeline flush on taken branch/jump/interrupt.

Parameters:
- DATA_W, 8, byte/opcode width.
- MAX_BYTES, 3, maximum instruction length in bytes (>=1); decoded lengths above this are clamped.
- DEPTH, 2, number of assembled-instruction queue entries (power of 2, >=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of the queue and any partial instruction.
- in_valid  in  1  fetch byte valid.
- in_data  in  DATA_W  fetch byte.
- in_ready  out  1  byte accepted when in_valid & in_ready at posedge.
- out_valid  out  1  head instruction available.
- out_opcode  out  DATA_W  head opcode.
- out_operand  out  (MAX_BYTES-1)*DATA_W  byte2 at [DATA_W-1:0], byte3 next; unused bytes zero.
- out_len  out  2  head length in bytes (1..MAX_BYTES).
- out_ready  in  1  consumer pops head when out_valid & out_ready at posedge.
- count  out  $clog2(DEPTH+1)  queued complete instructions.
- asm_busy  out  1  partial instruction held (opcode accepted, operands pending).

Behaviour:
- Reset state: all outputs 0 except in_ready=1; FSM=IDLE; queue empty.
- Length rule (package function ilen): opcode[7:6]==2'b11 -> 3; ==2'b10 -> 2; else 1. Result is clamped to MAX_BYTES.
- FSM IDLE: an accepted byte becomes the opcode and need = ilen-1.
  - need==0 -> push entry, stay IDLE.
  - else -> OPND, asm_busy=1.
- FSM OPND: each accepted byte is stored at operand index idx (0,1,...) and need is decremented.
  - Last byte -> push entry, go IDLE, asm_busy=0.
- in_ready rule:
  - 0 while flush=1.
  - Otherwise 1, except when the next byte would complete an instruction (IDLE with ilen==1 is not knowable ahead, so the rule is applied conservatively): in_ready = !flush & (count<DEPTH).
  - There is no combinational path from out_ready to in_ready. A pop in the same cycle does not free space until the next cycle.
- Queue:
  - FIFO; out_valid = (count!=0).
  - Head fields are stable while out_valid & !out_ready.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo DEPTH.
- Latency: last byte of an instruction accepted at edge N with queue empty -> out_valid=1 after edge N. A pop at edge M exposes the next entry after edge M.
- Flush:
  - Priority over push and pop.
  - At the flush edge: count=0, out_valid=0, FSM=IDLE, asm_busy=0, partial bytes discarded.
  - The byte presented in the flush cycle is not accepted.
- Reset mid-assembly: immediate return to the reset state; no partial entry survives.
- Unused operand bytes of a shorter instruction are written as zero; stale data never appears.

Decomposition:
- Package dyna85_pkg holds:
  - ILEN_3_PREFIX=2'b11 and ILEN_2_PREFIX=2'b10;
  - the ilen() function;
  - the FSM state typedef {IDLE, OPND}.
- One natural sub-module: instr_queue_fifo (DEPTH x entry-width synchronous FIFO with push/pop/flush/count). The assembler FSM stays in the top module.

Test Plan:
- Reset, then stream 0x3E -> out_valid after the accept edge, out_opcode=0x3E, out_len=1, out_operand=0x0000, asm_busy stays 0.
- Stream 0xC3,0x34,0x12 with out_ready=1 -> single entry: opcode 0xC3, out_len=3, out_operand=0x1234. asm_busy=1 after bytes 1-2, 0 after byte 3.
- DEPTH=2, out_ready=0, stream 0x01,0x02,0x03 -> count=2, in_ready=0 with 0x03 held. Assert out_ready for one cycle -> pop 0x01, then 0x03 is accepted the following cycle, count=2, order 0x02,0x03.
- Stream 0x85,0xAA, then assert flush while 0xBB is presented -> count=0, asm_busy=0, 0xBB not accepted. A following 0x01 yields opcode 0x01, len 1.
- Stream 0xC3,0x34 then pulse reset -> all outputs at reset values. Subsequent 0x80,0x55 -> opcode 0x80, len 2, operand 0x0055.
- Random valid/ready stress against a reference model for 10k bytes with MAX_BYTES=2 -> 3-byte opcodes report len 2, and there is no loss, duplication or reordering.
